wb_cache: RTL and testbench

Parametrised direct-mapped write-back data cache for the OoOP memory stage, with two independent read ports and one write port. Every write allocates its line and marks it dirty. A conflicting dirty line is pushed into an eviction FIFO that drains to memory under a valid/ready handshake. A flush state machine writes back every dirty line on request.

---
 rtl/wb_cache_if.sv | 35 +++
 rtl/wb_cache.sv | 208 ++++++++++++++++++++
 tb/tb_wb_cache.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cache_if.sv
// rtl/wb_cache_if.sv - Bus bundle for wb_cache: two read ports, write port, eviction stream, flush control
interface wb_cache_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] raddr0;
   logic                  rvalid0;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [ADDR_WIDTH-1:0] raddr1;
   logic                  rvalid1;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wready;
   logic                  evict_valid;
   logic [ADDR_WIDTH-1:0] evict_addr;
   logic [DATA_WIDTH-1:0] evict_data;
   logic                  evict_ready;
   logic                  flush_req;
   logic                  flush_busy;
   logic                  flush_done;

   modport master (
      output raddr0, raddr1, wen, waddr, wdata, evict_ready, flush_req,
      input  rvalid0, rdata0, rvalid1, rdata1, wready,
             evict_valid, evict_addr, evict_data, flush_busy, flush_done
   );

   modport slave (
      input  raddr0, raddr1, wen, waddr, wdata, evict_ready, flush_req,
      output rvalid0, rdata0, rvalid1, rdata1, wready,
             evict_valid, evict_addr, evict_data, flush_busy, flush_done
   );
endinterface

// File: rtl/wb_cache.sv
// rtl/wb_cache.sv - Direct-mapped write-back cache with eviction FIFO and flush FSM; WB_CACHE_FWD_EN enables write-to-read forwarding
module wb_cache #(
   parameter int ADDR_WIDTH  = 15,
   parameter int DATA_WIDTH  = 16,
   parameter int INDEX_WIDTH = 6,
   parameter int DELAY       = 1,
   parameter int EVICT_DEPTH = 4
) (
   input logic       clk,
   input logic       rst_n,
   wb_cache_if.slave bus
);
   localparam int NUM_SETS  = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
   localparam int PTR_WIDTH = $clog2(EVICT_DEPTH);
   localparam int CNT_WIDTH = PTR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Line storage; only valid/dirty carry reset
   logic [DATA_WIDTH-1:0]  data_mem [NUM_SETS];
   logic [TAG_WIDTH-1:0]   tag_mem  [NUM_SETS];
   logic [NUM_SETS-1:0]    valid_q;
   logic [NUM_SETS-1:0]    dirty_q;

   state_t                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic                   run_q;

   logic [ADDR_WIDTH-1:0]  fifo_addr [EVICT_DEPTH];
   logic [DATA_WIDTH-1:0]  fifo_data [EVICT_DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_WIDTH-1:0]   count_q;
   logic                   fifo_full, push, pop, flush_push, evict_valid;
   logic [ADDR_WIDTH-1:0]  push_addr;
   logic [DATA_WIDTH-1:0]  push_data;

   logic                   wready, wr_acc, wr_evict;
   logic [INDEX_WIDTH-1:0] w_idx;
   logic [TAG_WIDTH-1:0]   w_tag;

   // A pop on the same edge is deliberately not credited, so pushes never overflow
   assign fifo_full = (count_q == CNT_WIDTH'(EVICT_DEPTH));
   assign wready    = run_q && (state_q == IDLE) && !fifo_full;
   assign wr_acc    = bus.wen && wready;
   assign w_idx     = bus.waddr[INDEX_WIDTH-1:0];
   assign w_tag     = bus.waddr[ADDR_WIDTH-1:INDEX_WIDTH];
   assign wr_evict  = wr_acc && valid_q[w_idx] && dirty_q[w_idx] && (tag_mem[w_idx] != w_tag);

   // Writes and flush pushes are mutually exclusive because wready requires IDLE
   assign push      = wr_evict || flush_push;
   assign push_addr = flush_push ? {tag_mem[ptr_q], ptr_q} : {tag_mem[w_idx], w_idx};
   assign push_data = flush_push ? data_mem[ptr_q] : data_mem[w_idx];
   assign evict_valid = (count_q != '0);
   assign pop       = evict_valid && bus.evict_ready;

   assign bus.wready      = wready;
   assign bus.evict_valid = evict_valid;
   assign bus.evict_addr  = evict_valid ? fifo_addr[rd_ptr_q] : '0;
   assign bus.evict_data  = evict_valid ? fifo_data[rd_ptr_q] : '0;
   assign bus.flush_busy  = (state_q != IDLE);
   assign bus.flush_done  = (state_q == DONE);

   // Flush FSM next-state: walk every set, pushing dirty lines while the FIFO has room
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      flush_push = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.flush_req) begin
               state_d = SCAN;
               ptr_d   = '0;
            end
         end
         SCAN: begin
            if (!(valid_q[ptr_q] && dirty_q[ptr_q]) || !fifo_full) begin
               flush_push = valid_q[ptr_q] && dirty_q[ptr_q];
               if (&ptr_q) state_d = DONE;
               else        ptr_d   = ptr_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Flush FSM state, scan pointer, and the post-reset write enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         run_q   <= 1'b1;
      end
   end

   // Line data and tag: written on every accepted write
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         data_mem[w_idx] <= bus.wdata;
         tag_mem[w_idx]  <= w_tag;
      end
   end

   // Valid/dirty: writes allocate dirty, flush cleans the written-back line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (wr_acc) begin
            valid_q[w_idx] <= 1'b1;
            dirty_q[w_idx] <= 1'b1;
         end
         if (flush_push) dirty_q[ptr_q] <= 1'b0;
      end
   end

   // Eviction FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Eviction FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_q] <= push_addr;
         fifo_data[wr_ptr_q] <= push_data;
      end
   end

   logic [ADDR_WIDTH-1:0] raddr_a  [2];
   logic [ADDR_WIDTH-1:0] look_a   [2];
   logic                  rvalid_a [2];
   logic [DATA_WIDTH-1:0] rdata_a  [2];

   assign raddr_a[0]  = bus.raddr0;
   assign raddr_a[1]  = bus.raddr1;
   assign bus.rvalid0 = rvalid_a[0];
   assign bus.rdata0  = rdata_a[0];
   assign bus.rvalid1 = rvalid_a[1];
   assign bus.rdata1  = rdata_a[1];

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic                   rv_q;
      logic [DATA_WIDTH-1:0]  rd_q;
      logic [INDEX_WIDTH-1:0] l_idx;
      logic [TAG_WIDTH-1:0]   l_tag;
      logic                   hit;

      if (DELAY == 1) begin : g_nopipe
         assign look_a[p] = raddr_a[p];
      end else begin : g_pipe
         logic [ADDR_WIDTH-1:0] stage_q [DELAY-1];
         // Address delay line; the oldest stage feeds the lookup
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DELAY-1; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= raddr_a[p];
               for (int i = 1; i < DELAY-1; i++) stage_q[i] <= stage_q[i-1];
            end
         end
         assign look_a[p] = stage_q[DELAY-2];
      end

      assign l_idx = look_a[p][INDEX_WIDTH-1:0];
      assign l_tag = look_a[p][ADDR_WIDTH-1:INDEX_WIDTH];
      assign hit   = valid_q[l_idx] && (tag_mem[l_idx] == l_tag);

      // Registered lookup against pre-write array state; data holds on a miss
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rv_q <= 1'b0;
            rd_q <= '0;
         end else begin
`ifdef WB_CACHE_FWD_EN
            if (wr_acc && (bus.waddr == look_a[p])) begin
               rv_q <= 1'b1;
               rd_q <= bus.wdata;
            end else
`endif
            if (hit) begin
               rv_q <= 1'b1;
               rd_q <= data_mem[l_idx];
            end else begin
               rv_q <= 1'b0;
            end
         end
      end

      assign rvalid_a[p] = rv_q;
      assign rdata_a[p]  = rd_q;
   end
endmodule

// File: tb/tb_wb_cache.sv
// tb/tb_wb_cache.sv - Directed and randomised self-checking bench for wb_cache against a behavioural model
module tb_wb_cache;
   localparam int AW    = 15;
   localparam int DW    = 16;
   localparam int IW    = 6;
   localparam int DELAY = 2;
   localparam int DEPTH = 4;
   localparam int NSETS = 1 << IW;
   localparam int TW    = AW - IW;
`ifdef WB_CACHE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   wb_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   wb_cache #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW),
      .DELAY(DELAY), .EVICT_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Behavioural model: sets as arrays, FIFO as a queue, flush as a pointer walk
   bit            m_valid [NSETS];
   bit            m_dirty [NSETS];
   logic [TW-1:0] m_tag   [NSETS];
   logic [DW-1:0] m_data  [NSETS];
   ev_t           m_fifo [$];
   ev_t           ev_log [$];
   logic [AW-1:0] q_addr0 [$];
   logic [AW-1:0] q_addr1 [$];
   int            m_fst;
   int            m_ptr;
   bit            m_run;
   logic          m_rv [2];
   logic [DW-1:0] m_rd [2];

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_wready();
      return m_run && (m_fst == 0) && (m_fifo.size() < DEPTH);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NSETS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_fifo.delete();
      q_addr0.delete();
      q_addr1.delete();
      for (int i = 0; i < DELAY-1; i++) begin
         q_addr0.push_back('0);
         q_addr1.push_back('0);
      end
      m_fst = 0;
      m_ptr = 0;
      m_run = 1'b0;
      for (int p = 0; p < 2; p++) begin
         m_rv[p] = 1'b0;
         m_rd[p] = '0;
      end
   endtask

   task automatic model_edge();
      logic [AW-1:0] la [2];
      logic [TW-1:0] rt, wtag;
      int            ri, widx, old_size;
      bit            pop, acc, adv;
      ev_t           e;
      q_addr0.push_back(bus.raddr0);
      q_addr1.push_back(bus.raddr1);
      la[0]    = q_addr0.pop_front();
      la[1]    = q_addr1.pop_front();
      old_size = m_fifo.size();
      pop      = bus.evict_ready && (old_size > 0);
      acc      = bus.wen && m_wready();
      widx     = int'(bus.waddr[IW-1:0]);
      wtag     = bus.waddr[AW-1:IW];
      for (int p = 0; p < 2; p++) begin
         ri = int'(la[p][IW-1:0]);
         rt = la[p][AW-1:IW];
         if (FWD && acc && (bus.waddr == la[p])) begin
            m_rv[p] = 1'b1;
            m_rd[p] = bus.wdata;
         end else if (m_valid[ri] && (m_tag[ri] == rt)) begin
            m_rv[p] = 1'b1;
            m_rd[p] = m_data[ri];
         end else begin
            m_rv[p] = 1'b0;
         end
      end
      if (acc) begin
         if (m_valid[widx] && m_dirty[widx] && (m_tag[widx] != wtag)) begin
            e.a = {m_tag[widx], bus.waddr[IW-1:0]};
            e.d = m_data[widx];
            m_fifo.push_back(e);
         end
         m_valid[widx] = 1'b1;
         m_dirty[widx] = 1'b1;
         m_tag[widx]   = wtag;
         m_data[widx]  = bus.wdata;
      end
      if (m_fst == 1) begin
         adv = 1'b1;
         if (m_valid[m_ptr] && m_dirty[m_ptr]) begin
            if (old_size < DEPTH) begin
               e.a = AW'((int'(m_tag[m_ptr]) << IW) + m_ptr);
               e.d = m_data[m_ptr];
               m_fifo.push_back(e);
               m_dirty[m_ptr] = 1'b0;
            end else begin
               adv = 1'b0;
            end
         end
         if (adv) begin
            if (m_ptr == NSETS-1) m_fst = 2;
            else                  m_ptr++;
         end
      end else if (m_fst == 2) begin
         m_fst = 0;
      end else if (bus.flush_req) begin
         m_fst = 1;
         m_ptr = 0;
      end
      if (pop) void'(m_fifo.pop_front());
      m_run = 1'b1;
   endtask

   // Check this cycle's outputs, log observed evictions, advance model and clock
   task automatic cycle();
      #1;
      check("wready", bus.wready, m_wready());
      check("evict_valid", bus.evict_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
         check("evict_addr", bus.evict_addr, m_fifo[0].a);
         check("evict_data", bus.evict_data, m_fifo[0].d);
      end
      check("flush_busy", bus.flush_busy, m_fst != 0);
      check("flush_done", bus.flush_done, m_fst == 2);
      check("rvalid0", bus.rvalid0, m_rv[0]);
      check("rdata0", bus.rdata0, m_rd[0]);
      check("rvalid1", bus.rvalid1, m_rv[1]);
      check("rdata1", bus.rdata1, m_rd[1]);
      if (bus.evict_valid && bus.evict_ready) ev_log.push_back({bus.evict_addr, bus.evict_data});
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rvalid0"}, bus.rvalid0, 0);
      check({tag, "_rdata0"}, bus.rdata0, 0);
      check({tag, "_rvalid1"}, bus.rvalid1, 0);
      check({tag, "_rdata1"}, bus.rdata1, 0);
      check({tag, "_wready"}, bus.wready, 0);
      check({tag, "_evict_valid"}, bus.evict_valid, 0);
      check({tag, "_evict_addr"}, bus.evict_addr, 0);
      check({tag, "_evict_data"}, bus.evict_data, 0);
      check({tag, "_flush_busy"}, bus.flush_busy, 0);
      check({tag, "_flush_done"}, bus.flush_done, 0);
   endtask

   task automatic do_reset(input string tag);
      rst_n         = 1'b0;
      bus.wen       = 1'b0;
      bus.flush_req = 1'b0;
      #1;
      check_zero(tag);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check({tag, "_wready_after"}, bus.wready, 1);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wen   = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      cycle();
      bus.wen   = 1'b0;
   endtask

   task automatic run_flush(output int busy, output int done_at);
      busy    = 0;
      done_at = -1;
      bus.flush_req = 1'b1;
      cycle();
      bus.flush_req = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!bus.flush_busy) break;
         busy++;
         if (bus.flush_done) done_at = busy;
         cycle();
      end
      check("flush_end", bus.flush_busy, 0);
   endtask

   initial begin
      logic [AW-1:0] exp_a [3];
      logic [DW-1:0] exp_d [3];
      int busy, done_at;
      bus.raddr0 = '0; bus.raddr1 = '0;
      bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
      bus.evict_ready = 1'b0; bus.flush_req = 1'b0;
      #2;
      do_reset("rst0");

      // Write then dual-port read hit
      wr(15'h0040, 16'hBEEF);
      bus.raddr0 = 15'h0040;
      bus.raddr1 = 15'h0040;
      repeat (DELAY) cycle();
      check("t1_rvalid0", bus.rvalid0, 1);
      check("t1_rdata0", bus.rdata0, 16'hBEEF);
      check("t1_rvalid1", bus.rvalid1, 1);
      check("t1_rdata1", bus.rdata1, 16'hBEEF);

      // Conflicting dirty line is evicted, old address now misses
      do_reset("rst1");
      bus.evict_ready = 1'b0;
      wr(15'h0005, 16'h1111);
      wr(15'h0105, 16'h2222);
      check("t2_evict_valid", bus.evict_valid, 1);
      check("t2_evict_addr", bus.evict_addr, 15'h0005);
      check("t2_evict_data", bus.evict_data, 16'h1111);
      bus.raddr0 = 15'h0005;
      bus.raddr1 = 15'h0105;
      repeat (DELAY) cycle();
      check("t2_miss", bus.rvalid0, 0);
      check("t2_hit", bus.rvalid1, 1);
      check("t2_hit_data", bus.rdata1, 16'h2222);

      // Fill the FIFO to stall writes, then one pop releases it
      do_reset("rst2");
      bus.evict_ready = 1'b0;
      wr(15'h0007, 16'h0000);
      for (int t = 1; t <= DEPTH; t++) wr(AW'((t << IW) | 7), DW'(t));
      check("t3_wready_full", bus.wready, 0);
      bus.evict_ready = 1'b1;
      cycle();
      bus.evict_ready = 1'b0;
      check("t3_wready_back", bus.wready, 1);

      // Flush of sets 0, 3, 63 in index order, then an empty flush
      do_reset("rst3");
      bus.evict_ready = 1'b1;
      wr(15'h0000, 16'hA000);
      wr(15'h0003, 16'hA003);
      wr(15'h003F, 16'hA03F);
      ev_log.delete();
      run_flush(busy, done_at);
      check("t4_busy_cycles", busy, NSETS + 1);
      check("t4_done_at", done_at, NSETS + 1);
      check("t4_n_evict", ev_log.size(), 3);
      exp_a[0] = 15'h0000; exp_a[1] = 15'h0003; exp_a[2] = 15'h003F;
      exp_d[0] = 16'hA000; exp_d[1] = 16'hA003; exp_d[2] = 16'hA03F;
      for (int i = 0; i < 3; i++) begin
         if (i < ev_log.size()) begin
            check("t4_ev_addr", ev_log[i].a, exp_a[i]);
            check("t4_ev_data", ev_log[i].d, exp_d[i]);
         end
      end
      ev_log.delete();
      run_flush(busy, done_at);
      check("t4_second_busy", busy, NSETS + 1);
      check("t4_second_n_evict", ev_log.size(), 0);

      // Write and lookup of the same address on the same edge
      do_reset("rst4");
      bus.raddr0 = 15'h0010;
      wr(15'h0010, 16'h1234);
      repeat (3) cycle();
      wr(15'h0010, 16'h5678);
      check("t5_rvalid", bus.rvalid0, 1);
      check("t5_rdata", bus.rdata0, FWD ? 16'h5678 : 16'h1234);

      // Reset in the middle of a flush with a non-empty FIFO
      do_reset("rst5");
      bus.evict_ready = 1'b0;
      wr(15'h0021, 16'h5555);
      wr(15'h0061, 16'h6666);
      bus.raddr0 = 15'h0061;
      bus.flush_req = 1'b1;
      cycle();
      bus.flush_req = 1'b0;
      repeat (5) cycle();
      check("t6_pre_busy", bus.flush_busy, 1);
      check("t6_pre_evict", bus.evict_valid, 1);
      check("t6_pre_rvalid", bus.rvalid0, 1);
      #2;
      do_reset("t6_rst");
      bus.raddr0 = 15'h0061;
      repeat (DELAY) cycle();
      check("t6_miss", bus.rvalid0, 0);

      // Randomised traffic over a small address pool to force hits and conflicts
      do_reset("rst6");
      for (int n = 0; n < 4000; n++) begin
         bus.raddr0      = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 7));
         bus.raddr1      = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 7));
         bus.wen         = ($urandom_range(0, 1) == 1);
         bus.waddr       = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 7));
         bus.wdata       = DW'($urandom);
         bus.evict_ready = ($urandom_range(0, 2) != 0);
         bus.flush_req   = ($urandom_range(0, 99) == 0);
         cycle();
      end
      bus.wen = 1'b0;
      bus.flush_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
